// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer channels in, one registered stream out.
// The packet-lock sideband (last_i/last_o) exists only under STREAM_MUX_LOCK_EN.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode_i;
  logic [SEL_W-1:0]          sel_i;
  logic [CHANNELS-1:0]       valid_i;
  logic [CHANNELS*WIDTH-1:0] data_i;
  logic [CHANNELS-1:0]       ready_o;
  logic                      valid_o;
  logic [WIDTH-1:0]          data_o;
  logic [SEL_W-1:0]          src_o;
  logic                      ready_i;
`ifdef STREAM_MUX_LOCK_EN
  logic [CHANNELS-1:0]       last_i;
  logic                      last_o;

  modport slave  (input  mode_i, sel_i, valid_i, data_i, ready_i, last_i,
                  output ready_o, valid_o, data_o, src_o, last_o);
  modport master (output mode_i, sel_i, valid_i, data_i, ready_i, last_i,
                  input  ready_o, valid_o, data_o, src_o, last_o);
`else
  modport slave  (input  mode_i, sel_i, valid_i, data_i, ready_i,
                  output ready_o, valid_o, data_o, src_o);
  modport master (output mode_i, sel_i, valid_i, data_i, ready_i,
                  input  ready_o, valid_o, data_o, src_o);
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with one output register; external-select or round-robin grant.
// Optional packet lock (last_i/last_o) enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  stream_mux_rr_if.slave    bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] din;
  logic [CHANNELS-1:0]            vin;
  logic                           can_accept;
  logic                           gnt_vld;
  logic [SEL_W-1:0]               gnt_idx;
  logic [CHANNELS-1:0]            rdy;
  logic                           xfer;

  logic                           vld_q;
  logic [WIDTH-1:0]               data_q;
  logic [SEL_W-1:0]               src_q;
  logic [SEL_W-1:0]               ptr;

`ifdef STREAM_MUX_LOCK_EN
  logic                           lock;
  logic [SEL_W-1:0]               lock_ch;
  logic                           last_q;
`endif

  assign din = bus.data_i;
  assign vin = bus.valid_i;

  // No acceptance during reset so a reset cycle never consumes an upstream beat.
  assign can_accept = !rst && (!vld_q || bus.ready_i);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!bus.mode_i) begin
      for (int k = 0; k < CHANNELS; k++)
        if (bus.sel_i == SEL_W'(k) && vin[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(k);
        end
    end else begin
      // Walk farthest-to-nearest from ptr so the nearest valid channel wins.
      for (int i = CHANNELS; i >= 1; i--)
        for (int k = 0; k < CHANNELS; k++)
          if (k == (int'(ptr) + i) % CHANNELS && vin[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(k);
          end
    end
`ifdef STREAM_MUX_LOCK_EN
    if (lock) begin
      gnt_vld = vin[lock_ch];
      gnt_idx = lock_ch;
    end
`endif
  end

  always_comb begin
    rdy = '0;
    for (int k = 0; k < CHANNELS; k++)
      rdy[k] = can_accept && gnt_vld && (gnt_idx == SEL_W'(k));
  end

  assign xfer = can_accept && gnt_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      ptr    <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      vld_q  <= 1'b1;
      data_q <= din[gnt_idx];
      src_q  <= gnt_idx;
      if (bus.mode_i) ptr <= gnt_idx;
    end else if (bus.ready_i) begin
      vld_q  <= 1'b0;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // A non-last beat pins the grant to its channel until that channel sends last.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_ch <= '0;
      last_q  <= 1'b0;
    end else if (xfer) begin
      last_q <= bus.last_i[gnt_idx];
      if (!bus.last_i[gnt_idx]) begin
        lock    <= 1'b1;
        lock_ch <= gnt_idx;
      end else begin
        lock    <= 1'b0;
      end
    end
  end
  assign bus.last_o = last_q;
`endif

  assign bus.ready_o = rdy;
  assign bus.valid_o = vld_q;
  assign bus.data_o  = data_q;
  assign bus.src_o   = src_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, external select, round-robin, stall and
// (with STREAM_MUX_LOCK_EN) packet lock, all against hand-computed expectations.
module tb_stream_mux_rr;
  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.mode_i  = 1'b1;
    bus.sel_i   = '0;
    bus.valid_i = 4'b1111;
    bus.ready_i = 1'b1;
    for (int k = 0; k < CHANNELS; k++) bus.data_i[k*WIDTH +: WIDTH] = 32'h100 + k;
`ifdef STREAM_MUX_LOCK_EN
    bus.last_i  = 4'b1111;
`endif
    step();
    step();
    #1;
    chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("rst_data",  bus.data_o, 32'd0);
    chk("rst_src",   {30'b0, bus.src_o}, 32'd0);
    chk("rst_ready", {28'b0, bus.ready_o}, 32'd0);
`ifdef STREAM_MUX_LOCK_EN
    chk("rst_last",  {31'b0, bus.last_o}, 32'd0);
`endif

    // Out of reset: the round-robin search begins at channel 0.
    rst = 1'b0;
    #1;
    chk("rr_first_grant", {28'b0, bus.ready_o}, 32'b0001);
    bus.valid_i = 4'b0000;
    step();

    // External select of channel 2.
    bus.mode_i  = 1'b0;
    bus.sel_i   = 2'd2;
    bus.valid_i = 4'b0100;
    bus.data_i[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    chk("ext_ready", {28'b0, bus.ready_o}, 32'b0100);
    step();
    bus.valid_i = 4'b0000;
    chk("ext_valid", {31'b0, bus.valid_o}, 32'd1);
    chk("ext_data",  bus.data_o, 32'hDEADBEEF);
    chk("ext_src",   {30'b0, bus.src_o}, 32'd2);
    step();
    chk("ext_drain_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("ext_hold_data",   bus.data_o, 32'hDEADBEEF);

    // Selected channel idle: nothing is granted even though others are valid.
    bus.sel_i   = 2'd1;
    bus.valid_i = 4'b1101;
    #1;
    chk("ext_nogrant_ready", {28'b0, bus.ready_o}, 32'd0);
    step();
    chk("ext_nogrant_valid", {31'b0, bus.valid_o}, 32'd0);

    // Round-robin, all channels valid, full throughput.
    bus.data_i[2*WIDTH +: WIDTH] = 32'h102;
    bus.mode_i  = 1'b1;
    bus.valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", {31'b0, bus.valid_o}, 32'd1);
      chk("rr_src",   {30'b0, bus.src_o}, i % 4);
      chk("rr_data",  bus.data_o, 32'h100 + (i % 4));
    end

    // Stall with channel 3's beat held.
    bus.ready_i = 1'b0;
    #1;
    chk("stall_ready_pre", {28'b0, bus.ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'b0, bus.valid_o}, 32'd1);
      chk("stall_src",   {30'b0, bus.src_o}, 32'd3);
      chk("stall_data",  bus.data_o, 32'h103);
      chk("stall_ready", {28'b0, bus.ready_o}, 32'd0);
    end
    bus.ready_i = 1'b1;
    #1;
    chk("unstall_ready", {28'b0, bus.ready_o}, 32'b0001);
    step();
    bus.valid_i = 4'b0000;
    chk("unstall_src",  {30'b0, bus.src_o}, 32'd0);
    chk("unstall_data", bus.data_o, 32'h100);
    step();
    chk("unstall_drain", {31'b0, bus.valid_o}, 32'd0);

`ifdef STREAM_MUX_LOCK_EN
    // ptr = 0: channel 1 wins first, then holds the grant until its last beat.
    bus.valid_i = 4'b1111;
    bus.last_i  = 4'b1101;
    step();
    chk("lock_src0", {30'b0, bus.src_o}, 32'd1);
    chk("lock_last0", {31'b0, bus.last_o}, 32'd0);
    #1;
    chk("lock_ready", {28'b0, bus.ready_o}, 32'b0010);
    step();
    bus.last_i = 4'b1111;
    chk("lock_src1", {30'b0, bus.src_o}, 32'd1);
    step();
    chk("lock_src2",  {30'b0, bus.src_o}, 32'd1);
    chk("lock_last2", {31'b0, bus.last_o}, 32'd1);
    step();
    bus.valid_i = 4'b0000;
    chk("unlock_src", {30'b0, bus.src_o}, 32'd2);
    step();
`endif

    // Reset mid-transfer discards the held beat and accepts nothing.
    bus.valid_i = 4'b0001;
    bus.ready_i = 1'b0;
    step();
    chk("pre_rst_valid", {31'b0, bus.valid_o}, 32'd1);
    rst = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    chk("rst_mid_ready", {28'b0, bus.ready_o}, 32'd0);
    step();
    chk("rst_mid_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("rst_mid_data",  bus.data_o, 32'd0);
    rst = 1'b0;
    bus.valid_i = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshake on every input and on the output.
- One output register stage.
- Two selection modes:
  - external select, which is the direct successor of the combinational 4:1 operand mux;
  - round-robin arbitration.
- Used in the core and bus fabric wherever several producers share one consumer, e.g. writeback sources or memory request ports.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (>= 2).
- SEL_W, $clog2(CHANNELS), select and source-index width (derived, not overridden).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode_i  input  1  0 = external select, 1 = round-robin.
- sel_i  input  SEL_W  channel index used when mode_i = 0.
- valid_i  input  CHANNELS  per-channel valid.
- data_i  input  CHANNELS*WIDTH  packed data; channel k occupies bits [k*WIDTH +: WIDTH].
- ready_o  output  CHANNELS  per-channel ready (combinational).
- valid_o  output  1  output register holds a beat.
- data_o  output  WIDTH  registered data.
- src_o  output  SEL_W  index of the channel that supplied data_o.
- ready_i  input  1  downstream ready.

Behaviour:
- Reset values: valid_o = 0, data_o = 0, src_o = 0, round-robin pointer ptr = CHANNELS-1 (so the first search starts at channel 0).
- Reset asserted mid-transfer discards the held beat; no input transfer is accepted in a reset cycle.
- can_accept = !valid_o || ready_i. This is a one-entry pipeline register and allows full throughput of 1 beat/cycle.
- Grant selection (combinational, one-hot or none):
  - mode_i = 0: grant = sel_i if sel_i < CHANNELS and valid_i[sel_i]. Otherwise no grant.
  - mode_i = 1: grant = the first k with valid_i[k], searching ptr+1, ptr+2, … with wrap-around modulo CHANNELS. If all valid_i = 0, there is no grant.
- ready_o[k] = can_accept && grant == k. All other ready_o bits are 0.
  - ready_o may depend on valid_i.
  - Upstream must not make valid_i depend on ready_o.
- Input transfer happens when valid_i[k] && ready_o[k]. On the next edge: valid_o = 1, data_o = data_i[k], src_o = k.
- Latency is 1 cycle from input transfer to valid_o.
- Output transfer happens when valid_o && ready_i.
  - If no new input transfer occurs in the same cycle, valid_o goes to 0 on the next edge.
  - data_o and src_o keep their last value when valid_o = 0.
- Simultaneous output and input transfer: the register reloads with no bubble.
- Stall: while valid_o && !ready_i, data_o and src_o are stable and all ready_o = 0.
- Pointer update:
  - ptr <= granted index on each input transfer with mode_i = 1.
  - ptr is unchanged in mode_i = 0 and on cycles with no transfer.
- mode_i and sel_i are sampled each cycle. A change affects only the next grant and never the held beat.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN (packet lock).
- Defined:
  - Adds ports last_i (input, CHANNELS) and last_o (output, 1). last_o is registered alongside data_o and is 0 at reset.
  - A transfer with last_i[k] = 0 sets lock = 1 and lock_ch = k.
  - While lock = 1, grant = lock_ch if valid_i[lock_ch], otherwise no grant. This applies in both modes and overrides sel_i and round-robin.
  - A transfer from lock_ch with last_i = 1 clears the lock.
  - ptr updates as normal.
  - Reset clears lock.
- Undefined: no last ports, no lock state, and every beat is arbitrated independently.

Test Plan:
- Reset → valid_o = 0, data_o = 0, src_o = 0, ready_o = 0000. First RR grant with valid_i = 1111 is channel 0.
- mode_i = 0, sel_i = 2, valid_i = 0100, data ch2 = 0xDEADBEEF, ready_i = 1 → ready_o = 0100. Next cycle valid_o = 1, data_o = 0xDEADBEEF, src_o = 2.
- mode_i = 0, sel_i = 1, valid_i = 1101 → ready_o = 0000 and valid_o stays 0, even though other channels are valid.
- mode_i = 1, valid_i = 1111 held, ready_i = 1 for 8 cycles → src_o sequence 0,1,2,3,0,1,2,3 with valid_o high every cycle (no bubbles).
- mode_i = 1, beat held with ready_i = 0 for 3 cycles → data_o and src_o stable, ready_o = 0000. When ready_i rises, the next beat loads in that same cycle.
- STREAM_MUX_LOCK_EN, mode_i = 1, ch1 sends 3 beats with last = 0,0,1 while ch0, ch2 and ch3 are valid → src_o = 1,1,1, then 2 (ptr = 1, so the search starts at 2).
